e_mdu: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage. Owns the HI/LO architectural registers.
- Produces the HILO value that is latched into the EX/MEM pipeline register alongside the ALU result.
- Models MIPS mult/div latency with a busy countdown. The hazard unit uses `busy` to stall E-stage MDU instructions.
- Honours the exception flush request so that a flushed instruction never modifies HI/LO.

---
 rtl/e_mdu_if.sv | 33 +++
 rtl/e_mdu.sv | 156 +++++++++++++++
 tb/tb_e_mdu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Interface bundling the e_mdu request/operand inputs and its result outputs.
//   req      : flush of the instruction currently in E
//   start    : E-stage instruction is an MDU arithmetic op (qualifies op)
//   op       : MDU operation code
//   A, B     : rs / rt operands (already forwarded)
//   busy     : multi-cycle operation in progress
//   HILO_out : MFHI/MFLO read value, 0 for any other op
//   hi, lo   : current HI / LO registers
// Modports: slave = the MDU, master = the pipeline driving it.
interface e_mdu_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;

    logic            req;
    logic            start;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic [XLEN-1:0] HILO_out;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport slave (
        input  req, start, op, A, B,
        output busy, HILO_out, hi, lo
    );

    modport master (
        output req, start, op, A, B,
        input  busy, HILO_out, hi, lo
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning the HI/LO architectural registers.
// The result is computed at the accept edge and held in pending registers;
// HI/LO are written when the busy countdown expires, modelling MIPS latency.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : e_mdu_if.slave (req, start, op, A, B -> busy, HILO_out, hi, lo)
// Parameters: MULT_CYCLES / DIV_CYCLES busy lengths (1..15).
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (op 9/10).
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0]  pend_q, pend_d;
    logic               pend_we_q, pend_we_d;
    logic [XLEN-1:0]    hi_q, hi_d;
    logic [XLEN-1:0]    lo_q, lo_d;

    logic signed [2*XLEN-1:0] a_sx, b_sx, prod_s;
    logic [2*XLEN-1:0]        prod_u;
    logic [XLEN-1:0]          quo_s, rem_s, quo_u, rem_u;
    logic                     is_mul, is_div, accept;

    // Operand arithmetic; sign-extended 64-bit operands give the exact signed product.
    always_comb begin
        a_sx   = {{XLEN{bus.A[XLEN-1]}}, bus.A};
        b_sx   = {{XLEN{bus.B[XLEN-1]}}, bus.B};
        prod_s = a_sx * b_sx;
        prod_u = {{XLEN{1'b0}}, bus.A} * {{XLEN{1'b0}}, bus.B};
        quo_s  = '0;
        rem_s  = '0;
        quo_u  = '0;
        rem_u  = '0;
        if (bus.B != '0) begin
            quo_u = bus.A / bus.B;
            rem_u = bus.A % bus.B;
            // Most-negative / -1 overflows; MIPS returns the dividend with zero remainder.
            if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
                quo_s = 32'h8000_0000;
                rem_s = '0;
            end else begin
                quo_s = XLEN'($signed(bus.A) / $signed(bus.B));
                rem_s = XLEN'($signed(bus.A) % $signed(bus.B));
            end
        end
    end

    // Op decode for accepted arithmetic instructions.
    always_comb begin
        is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (bus.op == OP_MADD) || (bus.op == OP_MADDU);
`endif
        is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        accept = (state_q == S_IDLE) && bus.start && !bus.req && (is_mul || is_div);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_we_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state: accept / MTHI-MTLO when idle, countdown and commit when busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_BUSY;
                    pend_we_d = 1'b1;
                    cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    unique case (bus.op)
                        OP_MULT:  pend_d = prod_s;
                        OP_MULTU: pend_d = prod_u;
                        OP_DIV:   pend_d = {rem_s, quo_s};
                        OP_DIVU:  pend_d = {rem_u, quo_u};
`ifdef MDU_MADD_EN
                        OP_MADD:  pend_d = {hi_q, lo_q} + prod_s;
                        OP_MADDU: pend_d = {hi_q, lo_q} + prod_u;
`endif
                        default:  pend_d = pend_q;
                    endcase
                    // Divide by zero still takes the full latency but leaves HI/LO alone.
                    if (is_div && bus.B == '0) begin
                        pend_we_d = 1'b0;
                    end
                end else if (!bus.start && !bus.req) begin
                    if (bus.op == OP_MTHI) hi_d = bus.A;
                    if (bus.op == OP_MTLO) lo_d = bus.A;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = S_IDLE;
                    pend_we_d = 1'b0;
                    pend_d    = '0;
                    if (pend_we_q) begin
                        hi_d = pend_q[2*XLEN-1:XLEN];
                        lo_d = pend_q[XLEN-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy     = (state_q == S_BUSY);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.HILO_out = (bus.op == OP_MFHI) ? hi_q :
                          (bus.op == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: expected HI/LO/latency are queued when an
// operation is driven and popped when busy falls.
module tb_e_mdu;
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic idle_bus();
        bus.start = 1'b0;
        bus.req   = 1'b0;
        bus.op    = OP_NONE;
        bus.A     = '0;
        bus.B     = '0;
    endtask

    // One-cycle MTHI/MTLO (or other non-start op) with optional flush.
    task automatic move_to(input logic [3:0] op, input logic [31:0] a, input logic rq);
        @(negedge clk);
        bus.op  = op;
        bus.A   = a;
        bus.req = rq;
        @(negedge clk);
        idle_bus();
    endtask

    // inj 1: issue a DIV start on the 2nd busy cycle; inj 2: MTHI on the last busy edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic rq, input int inj,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        exp_t e;
        int   cyc;
        e.hi = ehi; e.lo = elo; e.cyc = ecyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.req   = rq;
        sb.push_back(e);
        @(negedge clk);
        idle_bus();
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            cyc++;
            idle_bus();
            if (inj == 1 && cyc == 2) begin
                bus.start = 1'b1; bus.op = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
            end
            if (inj == 2 && cyc == ecyc) begin
                bus.op = OP_MTHI; bus.A = 32'hDEAD;
            end
            @(negedge clk);
        end
        idle_bus();
        e = sb.pop_front();
        check({tag, "_cyc"}, 64'(cyc), 64'(e.cyc));
        check({tag, "_hi"},  64'(bus.hi), 64'(e.hi));
        check({tag, "_lo"},  64'(bus.lo), 64'(e.lo));
    endtask

    initial begin
        logic [31:0]     ra, rb;
        longint unsigned p;
        idle_bus();
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a MULT aborts it.
        move_to(OP_MTLO, 32'h55, 1'b0);
        check("mtlo", 64'(bus.lo), 64'h55);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        idle_bus();
        check("mrst_busy1", 64'(bus.busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_busy", 64'(bus.busy), 64'd0);
        check("mrst_hi", 64'(bus.hi), 64'd0);
        check("mrst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("mrst_late_busy", 64'(bus.busy), 64'd0);
        check("mrst_late_lo", 64'(bus.lo), 64'd0);

        run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("divu0", OP_DIVU,  32'd7,         32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("divov", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 32'h8000_0000, 10);
        run_op("busy_start", OP_MULTU, 32'h1_0000, 32'h1_0000, 1'b0, 1, 32'h1, 32'h0, 5);
        run_op("busy_mthi",  OP_MULT,  32'd5, 32'd5, 1'b0, 2, 32'h0, 32'd25, 5);
        run_op("flush", OP_MULT, 32'd5, 32'd5, 1'b1, 0, 32'h0, 32'd25, 0);

        move_to(OP_MTHI, 32'h1234, 1'b1);
        check("mthi_req", 64'(bus.hi), 64'h0);
        move_to(OP_MTHI, 32'h1234, 1'b0);
        check("mthi", 64'(bus.hi), 64'h1234);
        @(negedge clk);
        bus.op = OP_MFHI;
        #1 check("mfhi", 64'(bus.HILO_out), 64'h1234);
        bus.op = OP_MFLO;
        #1 check("mflo", 64'(bus.HILO_out), 64'd25);
        bus.op = OP_NONE;
        #1 check("hilo_none", 64'(bus.HILO_out), 64'd0);

        move_to(OP_MTHI, 32'h0, 1'b0);
        move_to(OP_MTLO, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 1'b0, 0, 32'h1, 32'h0, 5);
`else
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 1'b0, 0, 32'h0, 32'hFFFF_FFFF, 0);
`endif
        @(negedge clk);
        bus.op = OP_MADDU;
        #1 check("hilo_madd", 64'(bus.HILO_out), 64'd0);
        bus.op = OP_NONE;

        // Random unsigned multiply/divide against 64-bit reference arithmetic.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom | 32'd1;
            p  = longint'(ra) * longint'(rb);
            run_op("r_multu", OP_MULTU, ra, rb, 1'b0, 0, p[63:32], p[31:0], 5);
            run_op("r_divu", OP_DIVU, ra, rb, 1'b0, 0, ra % rb, ra / rb, 10);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
